// File: rtl/regbank_arbiter.sv
// Shares one register-bank port between a buffered, non-stallable SPI path (S)
// and a req/ack local host (H), with round-robin arbitration on ties.
module regbank_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_req,
   input  logic              s_we,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_wdata,
   output logic [DATA_W-1:0] s_rdata,
   output logic              s_rvalid,
   output logic              s_ovf,
   input  logic              s_ovf_clr,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_ack,
   output logic [DATA_W-1:0] h_rdata,
   output logic [ADDR_W-1:0] rb_addr,
   output logic              rb_we,
   output logic [DATA_W-1:0] rb_wdata,
   input  logic [DATA_W-1:0] rb_rdata
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;
   state_t r_state, w_state_next;

   logic              r_fifo_we    [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_wdata [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]    r_count;

   logic              r_owner_h, r_last_h;
   logic [ADDR_W-1:0] r_op_addr;
   logic [DATA_W-1:0] r_op_wdata;
   logic              r_h_ack, r_s_rvalid, r_s_ovf;
   logic [DATA_W-1:0] r_s_rdata, r_h_rdata;

   logic              w_empty, w_full, w_s_pend, w_h_pend;
   logic              w_grant_s, w_grant_h, w_push, w_pop, w_drop;
   logic              w_op_we;
   logic [ADDR_W-1:0] w_op_addr;
   logic [DATA_W-1:0] w_op_wdata;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == FIFO_FULL);
   assign w_s_pend = !w_empty;
   // The ack cycle masks h_req so a finished request is never granted twice.
   assign w_h_pend = h_req && !r_h_ack;

   assign w_grant_s = (r_state == IDLE) && w_s_pend && (!w_h_pend || r_last_h);
   assign w_grant_h = (r_state == IDLE) && w_h_pend && !w_grant_s;

   assign w_pop  = w_grant_s;
   assign w_push = s_req && (!w_full || w_pop);
   assign w_drop = s_req && w_full && !w_pop;

   assign w_op_we    = w_grant_s ? r_fifo_we[r_rd_ptr]    : h_we;
   assign w_op_addr  = w_grant_s ? r_fifo_addr[r_rd_ptr]  : h_addr;
   assign w_op_wdata = w_grant_s ? r_fifo_wdata[r_rd_ptr] : h_wdata;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_we[r_wr_ptr]    <= s_we;
         r_fifo_addr[r_wr_ptr]  <= s_addr;
         r_fifo_wdata[r_wr_ptr] <= s_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_grant_s || w_grant_h) w_state_next = w_op_we ? WR : RD_ADDR;
         WR:      w_state_next = IDLE;
         RD_ADDR: w_state_next = RD_DATA;
         RD_DATA: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_owner_h  <= 1'b0;
         r_last_h   <= 1'b1;
         r_op_addr  <= '0;
         r_op_wdata <= '0;
         r_h_ack    <= 1'b0;
         r_s_rvalid <= 1'b0;
         r_s_ovf    <= 1'b0;
         r_s_rdata  <= '0;
         r_h_rdata  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase

         if (w_drop)         r_s_ovf <= 1'b1;
         else if (s_ovf_clr) r_s_ovf <= 1'b0;

         if (w_grant_s || w_grant_h) begin
            r_owner_h <= w_grant_h;
            r_last_h  <= w_grant_h;
            r_op_addr <= w_op_addr;
            // Write data only moves on writes so rb_wdata holds between them.
            if (w_op_we) r_op_wdata <= w_op_wdata;
         end

         r_h_ack    <= r_owner_h && ((r_state == WR) || (r_state == RD_DATA));
         r_s_rvalid <= !r_owner_h && (r_state == RD_DATA);
         if (r_state == RD_DATA) begin
            if (r_owner_h) r_h_rdata <= rb_rdata;
            else           r_s_rdata <= rb_rdata;
         end
      end
   end

   assign rb_addr  = r_op_addr;
   assign rb_wdata = r_op_wdata;
   assign rb_we    = (r_state == WR);
   assign h_ack    = r_h_ack;
   assign h_rdata  = r_h_rdata;
   assign s_rvalid = r_s_rvalid;
   assign s_rdata  = r_s_rdata;
   assign s_ovf    = r_s_ovf;
endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed latency/arbitration/overflow/reset scenarios
// plus randomized traffic checked against an ordering-level reference model.
module tb_regbank_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 6;
   localparam int FIFO_DEPTH = 4;
   localparam int EW = ADDR_W + DATA_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              s_req, s_we, s_ovf_clr, s_rvalid, s_ovf;
   logic [ADDR_W-1:0] s_addr, h_addr, rb_addr;
   logic [DATA_W-1:0] s_wdata, s_rdata, h_wdata, h_rdata, rb_wdata, rb_rdata;
   logic              h_req, h_we, h_ack, rb_we;

   int errors = 0;
   int checks = 0;

   regbank_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_ovf(s_ovf), .s_ovf_clr(s_ovf_clr),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_ack(h_ack), .h_rdata(h_rdata),
      .rb_addr(rb_addr), .rb_we(rb_we), .rb_wdata(rb_wdata), .rb_rdata(rb_rdata)
   );

   // Register bank model: registered read, write log of every strobe.
   logic [DATA_W-1:0] bank [64];
   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_data;
   logic [EW-1:0]     wlog [$];
   always @(posedge clk) begin
      if (pl_en) bank[pl_addr] <= pl_data;
      else if (rb_we) begin
         bank[rb_addr] <= rb_wdata;
         wlog.push_back({rb_addr, rb_wdata});
      end
      rb_rdata <= bank[rb_addr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_s_rvalid got=%0h exp=0", s_rvalid); end
      checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL reset_s_ovf got=%0h exp=0", s_ovf); end
      checks++; if (s_rdata !== '0) begin errors++; $display("FAIL reset_s_rdata got=%0h exp=0", s_rdata); end
      checks++; if (h_ack !== 1'b0) begin errors++; $display("FAIL reset_h_ack got=%0h exp=0", h_ack); end
      checks++; if (h_rdata !== '0) begin errors++; $display("FAIL reset_h_rdata got=%0h exp=0", h_rdata); end
      checks++; if (rb_we !== 1'b0) begin errors++; $display("FAIL reset_rb_we got=%0h exp=0", rb_we); end
      checks++; if (rb_addr !== '0) begin errors++; $display("FAIL reset_rb_addr got=%0h exp=0", rb_addr); end
      checks++; if (rb_wdata !== '0) begin errors++; $display("FAIL reset_rb_wdata got=%0h exp=0", rb_wdata); end
      rst = 1'b1;
      tick();
      $display("txn reset checked");
   endtask

   task automatic test_s_write;
      logic exp_we;
      s_req = 1'b1; s_we = 1'b1; s_addr = 6'h05; s_wdata = 32'hDEADBEEF;
      tick();
      s_req = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         exp_we = (c == 2);
         checks++; if (rb_we !== exp_we) begin errors++; $display("FAIL s_write_rb_we cycle=%0d got=%0h exp=%0h", c, rb_we, exp_we); end
         if (c == 2) begin
            checks++;
            if (rb_addr !== 6'h05 || rb_wdata !== 32'hDEADBEEF) begin
               errors++; $display("FAIL s_write_bus got=%0h/%0h exp=05/deadbeef", rb_addr, rb_wdata);
            end
         end
         checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL s_write_no_rvalid cycle=%0d got=%0h exp=0", c, s_rvalid); end
         if (c < 5) tick();
      end
      $display("txn S write addr=05 data=deadbeef");
   endtask

   task automatic test_s_read;
      logic exp_v;
      preload(6'h0A, 32'h12345678);
      s_req = 1'b1; s_we = 1'b0; s_addr = 6'h0A; s_wdata = '0;
      tick();
      s_req = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         exp_v = (c == 4);
         checks++; if (s_rvalid !== exp_v) begin errors++; $display("FAIL s_read_rvalid cycle=%0d got=%0h exp=%0h", c, s_rvalid, exp_v); end
         checks++; if (rb_we !== 1'b0) begin errors++; $display("FAIL s_read_rb_we cycle=%0d got=%0h exp=0", c, rb_we); end
         if (c >= 4) begin
            checks++; if (s_rdata !== 32'h12345678) begin errors++; $display("FAIL s_read_data cycle=%0d got=%0h exp=12345678", c, s_rdata); end
         end
         if (c < 6) tick();
      end
      $display("txn S read addr=0a data=%0h", s_rdata);
   endtask

   task automatic test_h_write_read;
      logic [DATA_W-1:0] d;
      int w0;
      logic exp_ack;
      d = $urandom;
      w0 = wlog.size();
      h_req = 1'b1; h_we = 1'b1; h_addr = 6'h03; h_wdata = d;
      tick();
      checks++; if (rb_we !== 1'b1 || rb_addr !== 6'h03 || rb_wdata !== d) begin errors++; $display("FAIL h_write_bus got=%0h/%0h/%0h exp=1/03/%0h", rb_we, rb_addr, rb_wdata, d); end
      checks++; if (h_ack !== 1'b0) begin errors++; $display("FAIL h_write_early_ack got=%0h exp=0", h_ack); end
      tick();
      checks++; if (h_ack !== 1'b1) begin errors++; $display("FAIL h_write_ack got=%0h exp=1", h_ack); end
      tick();
      h_req = 1'b0;
      for (int c = 3; c <= 6; c++) begin
         checks++; if (rb_we !== 1'b0 || h_ack !== 1'b0) begin errors++; $display("FAIL h_write_double cycle=%0d got=%0h/%0h exp=0/0", c, rb_we, h_ack); end
         tick();
      end
      checks++; if (wlog.size() - w0 != 1) begin errors++; $display("FAIL h_write_count got=%0d exp=1", wlog.size() - w0); end
      $display("txn H write addr=03 data=%0h", d);
      h_req = 1'b1; h_we = 1'b0; h_addr = 6'h03;
      for (int c = 1; c <= 5; c++) begin
         tick();
         exp_ack = (c == 3);
         if (c == 3) h_req = 1'b0;
         checks++; if (h_ack !== exp_ack) begin errors++; $display("FAIL h_read_ack cycle=%0d got=%0h exp=%0h", c, h_ack, exp_ack); end
         checks++; if (rb_we !== 1'b0) begin errors++; $display("FAIL h_read_rb_we cycle=%0d got=%0h exp=0", c, rb_we); end
      end
      checks++; if (h_rdata !== d) begin errors++; $display("FAIL h_read_data got=%0h exp=%0h", h_rdata, d); end
      $display("txn H read addr=03 data=%0h", h_rdata);
   endtask

   task automatic test_tie;
      logic [DATA_W-1:0] da, db, dc;
      logic [EW-1:0] exp_q [$];
      int w0, cyc, ack_cyc;
      do_reset();
      da = $urandom; db = $urandom; dc = $urandom;
      exp_q = '{{6'h11, da}, {6'h22, db}, {6'h12, dc}};
      w0 = wlog.size();
      s_req = 1'b1; s_we = 1'b1; s_addr = 6'h11; s_wdata = da;
      tick();
      s_addr = 6'h12; s_wdata = dc;
      h_req = 1'b1; h_we = 1'b1; h_addr = 6'h22; h_wdata = db;
      tick();
      s_req = 1'b0;
      cyc = 2; ack_cyc = -1;
      while (cyc < 30 && ack_cyc < 0) begin
         if (h_ack === 1'b1) begin ack_cyc = cyc; h_req = 1'b0; end
         else begin tick(); cyc++; end
      end
      checks++; if (ack_cyc != 5) begin errors++; $display("FAIL tie_h_ack_cycle got=%0d exp=5", ack_cyc); end
      h_req = 1'b0;
      repeat (6) tick();
      checks++; if (wlog.size() - w0 != 3) begin errors++; $display("FAIL tie_write_count got=%0d exp=3", wlog.size() - w0); end
      for (int i = 0; i < 3 && w0 + i < wlog.size(); i++) begin
         checks++; if (wlog[w0+i] !== exp_q[i]) begin errors++; $display("FAIL tie_order idx=%0d got=%0h exp=%0h", i, wlog[w0+i], exp_q[i]); end
      end
      $display("txn tie S/H/S grant order checked");
   endtask

   // H holds a write request while S pushes 6 writes back to back: only
   // 4 entries fit and the bank is shared, so the 6th push is dropped.
   task automatic test_overflow(input logic clr_at_drop);
      logic [DATA_W-1:0] d [6];
      logic [EW-1:0] e;
      logic [EW-1:0] s_list [$];
      int w0, hcount;
      w0 = wlog.size();
      h_req = 1'b1; h_we = 1'b1; h_addr = 6'h30; h_wdata = $urandom;
      for (int c = 0; c < 6; c++) begin
         checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early cycle=%0d got=%0h exp=0", c, s_ovf); end
         d[c] = $urandom;
         s_req = 1'b1; s_we = 1'b1; s_addr = ADDR_W'(8 + c); s_wdata = d[c];
         s_ovf_clr = clr_at_drop && (c == 5);
         tick();
      end
      s_req = 1'b0; s_ovf_clr = 1'b0;
      checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set clr=%0d got=%0h exp=1", clr_at_drop, s_ovf); end
      checks++; if (h_ack !== 1'b1) begin errors++; $display("FAIL ovf_h_ack got=%0h exp=1", h_ack); end
      h_req = 1'b0;
      repeat (12) tick();
      hcount = 0;
      for (int i = w0; i < wlog.size(); i++) begin
         e = wlog[i];
         if (e[DATA_W +: ADDR_W] < 6'd32) s_list.push_back(e);
         else hcount++;
      end
      checks++; if (s_list.size() != 5) begin errors++; $display("FAIL ovf_accepted got=%0d exp=5", s_list.size()); end
      checks++; if (hcount != 2) begin errors++; $display("FAIL ovf_h_writes got=%0d exp=2", hcount); end
      for (int i = 0; i < 5 && i < s_list.size(); i++) begin
         e = {ADDR_W'(8 + i), d[i]};
         checks++; if (s_list[i] !== e) begin errors++; $display("FAIL ovf_order idx=%0d got=%0h exp=%0h", i, s_list[i], e); end
      end
      checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0h exp=1", s_ovf); end
      s_ovf_clr = 1'b1;
      tick();
      s_ovf_clr = 1'b0;
      checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0h exp=0", s_ovf); end
      $display("txn overflow burst clr_at_drop=%0d accepted=%0d", clr_at_drop, s_list.size());
   endtask

   task automatic test_reset_mid;
      logic [DATA_W-1:0] d;
      logic exp_we;
      int w0;
      preload(6'h2A, 32'hCAFE0001);
      h_req = 1'b1; h_we = 1'b0; h_addr = 6'h2A;
      tick();
      s_req = 1'b1; s_we = 1'b1; s_addr = 6'h07; s_wdata = 32'h0BADF00D;
      tick();
      s_req = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (s_rvalid !== 1'b0 || s_ovf !== 1'b0 || s_rdata !== '0) begin errors++; $display("FAIL mid_reset_s got=%0h/%0h/%0h exp=0/0/0", s_rvalid, s_ovf, s_rdata); end
      checks++; if (h_ack !== 1'b0 || h_rdata !== '0) begin errors++; $display("FAIL mid_reset_h got=%0h/%0h exp=0/0", h_ack, h_rdata); end
      checks++; if (rb_we !== 1'b0 || rb_addr !== '0 || rb_wdata !== '0) begin errors++; $display("FAIL mid_reset_rb got=%0h/%0h/%0h exp=0/0/0", rb_we, rb_addr, rb_wdata); end
      h_req = 1'b0;
      tick(); tick();
      rst = 1'b1;
      w0 = wlog.size();
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++; if (h_ack !== 1'b0 || rb_we !== 1'b0) begin errors++; $display("FAIL mid_reset_after cycle=%0d got=%0h/%0h exp=0/0", c, h_ack, rb_we); end
      end
      checks++; if (wlog.size() != w0) begin errors++; $display("FAIL mid_reset_fifo_lost got=%0d exp=0", wlog.size() - w0); end
      d = $urandom;
      s_req = 1'b1; s_we = 1'b1; s_addr = 6'h15; s_wdata = d;
      tick();
      s_req = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         exp_we = (c == 2);
         checks++; if (rb_we !== exp_we) begin errors++; $display("FAIL mid_reset_latency cycle=%0d got=%0h exp=%0h", c, rb_we, exp_we); end
         if (c == 2) begin
            checks++; if (rb_addr !== 6'h15 || rb_wdata !== d) begin errors++; $display("FAIL mid_reset_bus got=%0h/%0h exp=15/%0h", rb_addr, rb_wdata, d); end
         end
         tick();
      end
      $display("txn reset during H read, then S write data=%0h", d);
   endtask

   // Random mixed traffic: S uses addresses 0-31, H uses 32-63, so each
   // owner's writes and reads can be predicted from its own program order.
   task automatic test_random;
      logic [DATA_W-1:0] s_mem [32], h_mem [32];
      bit s_ok [32], h_ok [32];
      logic [EW-1:0] s_wr_q [$], h_wr_q [$], e;
      logic [DATA_W-1:0] s_rd_q [$];
      logic [DATA_W-1:0] h_exp, d;
      logic [4:0] a;
      bit h_busy, h_is_read, acked, wr;
      int gap, cyc, n_txn;
      for (int i = 0; i < 32; i++) begin s_ok[i] = 0; h_ok[i] = 0; end
      h_busy = 0; h_is_read = 0; h_exp = '0; gap = 0; cyc = 0; n_txn = 0;
      while (cyc < 1500 || ((s_wr_q.size() != 0 || s_rd_q.size() != 0 || h_busy) && cyc < 1700)) begin
         if (rb_we === 1'b1) begin
            if (rb_addr < 6'd32) begin
               checks++;
               if (s_wr_q.size() == 0) begin errors++; $display("FAIL rand_s_write_unexpected got=%0h/%0h", rb_addr, rb_wdata); end
               else begin e = s_wr_q.pop_front(); if ({rb_addr, rb_wdata} !== e) begin errors++; $display("FAIL rand_s_write got=%0h exp=%0h", {rb_addr, rb_wdata}, e); end end
            end else begin
               checks++;
               if (h_wr_q.size() == 0) begin errors++; $display("FAIL rand_h_write_unexpected got=%0h/%0h", rb_addr, rb_wdata); end
               else begin e = h_wr_q.pop_front(); if ({rb_addr, rb_wdata} !== e) begin errors++; $display("FAIL rand_h_write got=%0h exp=%0h", {rb_addr, rb_wdata}, e); end end
            end
         end
         if (s_rvalid === 1'b1) begin
            checks++;
            if (s_rd_q.size() == 0) begin errors++; $display("FAIL rand_s_rvalid_unexpected got=%0h", s_rdata); end
            else begin d = s_rd_q.pop_front(); if (s_rdata !== d) begin errors++; $display("FAIL rand_s_read got=%0h exp=%0h", s_rdata, d); end end
         end
         acked = 0;
         if (h_ack === 1'b1) begin
            checks++;
            if (!h_busy) begin errors++; $display("FAIL rand_h_ack_unexpected got=1 exp=0"); end
            else if (h_is_read && h_rdata !== h_exp) begin errors++; $display("FAIL rand_h_read got=%0h exp=%0h", h_rdata, h_exp); end
            h_busy = 0; h_req = 1'b0; acked = 1;
         end
         s_req = 1'b0;
         if (cyc < 1500) begin
            if (gap == 0) begin
               a = 5'($urandom_range(0, 31));
               wr = !s_ok[a] || ($urandom_range(0, 1) == 1);
               s_req = 1'b1; s_we = wr; s_addr = {1'b0, a}; s_wdata = $urandom;
               if (wr) begin s_mem[a] = s_wdata; s_ok[a] = 1; s_wr_q.push_back({1'b0, a, s_wdata}); end
               else s_rd_q.push_back(s_mem[a]);
               gap = $urandom_range(6, 9);
               n_txn++;
            end else gap--;
            if (!h_busy && !acked && $urandom_range(0, 3) == 0) begin
               a = 5'($urandom_range(0, 31));
               wr = !h_ok[a] || ($urandom_range(0, 1) == 1);
               h_req = 1'b1; h_we = wr; h_addr = {1'b1, a}; h_wdata = $urandom;
               if (wr) begin h_mem[a] = h_wdata; h_ok[a] = 1; h_wr_q.push_back({1'b1, a, h_wdata}); end
               else h_exp = h_mem[a];
               h_busy = 1; h_is_read = !wr;
               n_txn++;
            end
         end
         tick();
         cyc++;
      end
      checks++; if (s_wr_q.size() != 0 || s_rd_q.size() != 0 || h_busy) begin errors++; $display("FAIL rand_drain got=%0d/%0d/%0d exp=0/0/0", s_wr_q.size(), s_rd_q.size(), h_busy); end
      checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL rand_no_ovf got=%0h exp=0", s_ovf); end
      $display("txn random traffic issued=%0d cycles=%0d", n_txn, cyc);
   endtask

   initial begin
      rst = 1'b0;
      s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_ovf_clr = 1'b0;
      h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      tick();
      test_reset();
      test_s_write();
      test_s_read();
      test_h_write_read();
      test_tie();
      test_overflow(1'b0);
      test_overflow(1'b1);
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Shares one register-bank access port between two requesters:
  - the SPI slave path (S), which cannot be stalled and so has its requests buffered;
  - a local host (H), which uses a req/ack handshake.
- Sequences each bank access (1-cycle write, 2-cycle registered read) and returns read data.
- Arbitrates round-robin when both requesters are pending.
- Sits between the SPI slave and the register bank, in place of the direct address/we/data connection.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 6, register address width
- FIFO_DEPTH, 4, S request buffer entries; power of 2, at least 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- s_req  in  1  1-cycle S request pulse
- s_we  in  1  S write (1) / read (0), sampled with s_req
- s_addr  in  ADDR_W  S address, sampled with s_req
- s_wdata  in  DATA_W  S write data, sampled with s_req
- s_rdata  out  DATA_W  S read data, valid when s_rvalid is high
- s_rvalid  out  1  1-cycle pulse: S read completed
- s_ovf  out  1  sticky flag: an S request was dropped
- s_ovf_clr  in  1  clears s_ovf
- h_req  in  1  H request level; held until h_ack
- h_we  in  1  H write/read; held stable with h_req
- h_addr  in  ADDR_W  H address
- h_wdata  in  DATA_W  H write data
- h_ack  out  1  1-cycle pulse: H access completed
- h_rdata  out  DATA_W  H read data, valid when h_ack is high after a read
- rb_addr  out  ADDR_W  bank address
- rb_we  out  1  bank write strobe
- rb_wdata  out  DATA_W  bank write data
- rb_rdata  in  DATA_W  bank read data, registered; valid the cycle after rb_addr is presented

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; FIFO empty.
  - All outputs are 0.
  - last_owner = H, so S wins the first tie.
- S FIFO:
  - Each entry holds {we, addr, wdata}; s_req pushes one entry.
  - Push while full with no pop in the same cycle: the entry is dropped and s_ovf is set.
  - Push and pop in the same cycle while full: accepted, nothing dropped.
  - Pointers wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
- s_ovf:
  - Set on a drop, cleared by s_ovf_clr.
  - Set and clear in the same cycle: set wins.
- FSM states: IDLE, WR, RD_ADDR, RD_DATA.
- Arbitration in IDLE:
  - S is pending when the FIFO is non-empty.
  - H is pending when h_req=1 and h_ack=0; h_req is ignored during the h_ack cycle, so a completed request cannot be re-granted.
  - One pending requester is granted; if both are pending, the one that is not last_owner is granted.
- On grant, registered at the edge:
  - op_we/op_addr/op_wdata/owner are latched from the FIFO head (which pops in that cycle) or from the H inputs; last_owner is updated.
  - Next state is WR if op_we=1, otherwise RD_ADDR.
- WR: rb_addr=op_addr, rb_wdata=op_wdata, rb_we=1 for exactly one cycle, then IDLE. If owner=H, h_ack pulses in the next cycle.
- RD_ADDR: rb_addr=op_addr, rb_we=0, then RD_DATA.
- RD_DATA:
  - rb_rdata is captured into s_rdata or h_rdata according to owner, then IDLE.
  - s_rvalid or h_ack pulses in the next cycle.
  - s_rdata/h_rdata hold their value until the next read for that owner.
- S writes produce no completion pulse (posted).
- Outside WR: rb_we=0; rb_addr and rb_wdata hold their last values.
- Throughput:
  - Back-to-back S writes: 1 per 2 cycles (IDLE, WR).
  - Reads: 1 per 3 cycles.
- Latency, idle system:
  - S write: s_req at cycle 0 gives rb_we=1 at cycle 2.
  - S read: s_req at cycle 0 gives s_rvalid at cycle 4.
  - H write: h_req rising at cycle 0 gives rb_we at cycle 1 and h_ack at cycle 2.
  - H read: h_ack at cycle 3.
- An access in progress is never pre-empted.
- A reset mid-access aborts it: no ack is issued and the FIFO contents are lost.

Test Plan:
- Reset, then S write {addr 0x05, data 0xDEADBEEF} -> rb_we=1 exactly one cycle at cycle 2 with rb_addr=0x05, rb_wdata=0xDEADBEEF; no s_rvalid.
- S read of addr 0x0A with bank model returning 0x12345678 -> s_rvalid pulses at cycle 4 with s_rdata=0x12345678.
- H write to 0x03, then H read of 0x03 -> h_ack 2 cycles after the write request; read h_ack 3 cycles after the read request with h_rdata equal to the written value; h_req held high across h_ack causes no double access.
- S and H requests in the same cycle, from reset -> S granted first, H second; a repeated tie alternates grants.
- 6 S write pulses while the bank is busy, FIFO_DEPTH=4 -> extra pulses are dropped and s_ovf=1; the accepted writes appear on the bank in push order; s_ovf_clr sets s_ovf=0, and s_ovf_clr coinciding with a drop leaves s_ovf=1.
- Assert rst during RD_DATA of an H read -> all outputs go to 0 immediately; no h_ack after release; the FIFO is empty and the next S request gets normal latency.
